// File: rtl/ps2_kb_writer_pkg.sv
// Shared definitions for the PS/2 keyboard writer: prefix scancodes,
// event word field positions, receiver state encoding and word packing.
package ps2_kb_writer_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  localparam int EXT_BIT = 8;
  localparam int REL_BIT = 9;
  localparam int SEQ_LSB = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

  // Pack one key event: [7:0] scancode, [8] extended, [9] release,
  // [15:10] zero, [31:16] sequence number.
  function automatic logic [31:0] event_word(input logic [15:0] seq,
                                             input logic        rel,
                                             input logic        ext,
                                             input logic [7:0]  code);
    logic [31:0] w;
    w                     = '0;
    w[7:0]                = code;
    w[EXT_BIT]            = ext;
    w[REL_BIT]            = rel;
    w[SEQ_LSB +: 16]      = seq;
    return w;
  endfunction

endpackage

// File: rtl/ps2_kb_writer_if.sv
// Write port from the keyboard writer into the memory map's kb_info word,
// plus the frame error pulse.
interface ps2_kb_writer_if;
  logic [31:0] kb_wraddr;
  logic [31:0] kb_wrdata;
  logic        kb_we;
  logic        frame_err;

  modport master (
    output kb_wraddr,
    output kb_wrdata,
    output kb_we,
    output frame_err
  );

  modport slave (
    input kb_wraddr,
    input kb_wrdata,
    input kb_we,
    input frame_err
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the raw keyboard lines, detects falling
// clock edges, shifts in an 11-bit frame, validates it and guards each frame
// with an inter-edge timeout. Emits one-cycle byte_valid / err pulses.
module ps2_rx_frame
  import ps2_kb_writer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       err,
  output logic       tmo
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             clk_s1, clk_s2, clk_prev;
  logic             dat_s1, dat_s2;
  logic             fall;
  logic             bit_in;
  rx_state_t        state;
  logic [3:0]       bit_cnt;
  logic [8:0]       shreg;
  logic [CNT_W-1:0] tmo_cnt;

  assign fall   = clk_prev & ~clk_s2;
  assign bit_in = dat_s2;

  // Two-flop synchronisers on both lines plus the previous synced clock
  // for edge detection; idle-high reset so no false edge leaves reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  // Frame FSM. The frame check is evaluated as the stop bit arrives so the
  // verdict pulse is registered and visible during the single CHECK cycle.
  // An edge always takes priority over the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      tmo_cnt    <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      err        <= 1'b0;
      tmo        <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      err        <= 1'b0;
      tmo        <= 1'b0;
      if (fall) tmo_cnt <= '0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (fall && !bit_in) state <= RECV;
        end
        RECV: begin
          if (fall) begin
            if (bit_cnt == 4'd9) begin
              state   <= CHECK;
              bit_cnt <= '0;
              rx_byte <= shreg[7:0];
              if (bit_in && (^shreg)) byte_valid <= 1'b1;
              else                    err        <= 1'b1;
            end else begin
              shreg   <= {bit_in, shreg[8:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tmo_cnt <= '0;
            err     <= 1'b1;
            tmo     <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_kb_writer.sv
// PS/2 keyboard writer: turns received scancode bytes into key event words
// (folding E0/F0 prefixes into flags) and writes them to the kb_info word.
module ps2_kb_writer
  import ps2_kb_writer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  ps2_kb_writer_if.master        kb
);

  logic        byte_valid;
  logic [7:0]  rx_byte;
  logic        rx_err;
  logic        rx_tmo;
  logic        ext;
  logic        rel;
  logic [15:0] seq;
  logic [15:0] seq_next;
  logic [31:0] wrdata;
  logic        we;
  logic        ferr;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .err        (rx_err),
    .tmo        (rx_tmo)
  );

  assign seq_next     = seq + 16'd1;
  assign kb.kb_wraddr = '0;
  assign kb.kb_wrdata = wrdata;
  assign kb.kb_we     = we;
  assign kb.frame_err = ferr;

  // Prefix tracking, sequence counter and registered write port. A bad
  // frame drops pending prefixes; a timeout leaves them in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext    <= 1'b0;
      rel    <= 1'b0;
      seq    <= '0;
      wrdata <= '0;
      we     <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      we   <= 1'b0;
      ferr <= 1'b0;
      if (byte_valid) begin
        case (rx_byte)
          SC_EXT: ext <= 1'b1;
          SC_BRK: rel <= 1'b1;
          default: begin
            seq    <= seq_next;
            wrdata <= event_word(seq_next, rel, ext, rx_byte);
            we     <= 1'b1;
            ext    <= 1'b0;
            rel    <= 1'b0;
          end
        endcase
      end else if (rx_err) begin
        ferr <= 1'b1;
        if (!rx_tmo) begin
          ext <= 1'b0;
          rel <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kb_writer.sv
// Bench for ps2_kb_writer: table of frames with expected events plus
// hand-written timeout, reset and sequence-wrap sequences; a monitor pops
// a scoreboard queue on every kb_we / frame_err pulse.
module tb_ps2_kb_writer;

  localparam int TMO   = 100;
  localparam int HALF  = 4;   // PS/2 half period in clk cycles

  logic clk;
  logic rst_n;
  logic ps2_clk;
  logic ps2_data;

  ps2_kb_writer_if kb ();

  ps2_kb_writer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kb       (kb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic [7:0]  code;
    logic        bad_par;
    logic        exp_we;
    logic        exp_err;
    logic [31:0] exp_word;
  } vec_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Scoreboard monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (kb.kb_we && kb.frame_err) begin
        checks++; errors++;
        $display("FAIL we_err_overlap: kb_we and frame_err both high");
      end
      if (kb.kb_we || kb.frame_err) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: we=%0b err=%0b data=0x%08h with nothing expected",
                   kb.kb_we, kb.frame_err, kb.kb_wrdata);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.is_err) begin
            if (!kb.frame_err) begin
              errors++;
              $display("FAIL pulse_kind: got write 0x%08h expected frame_err", kb.kb_wrdata);
            end
          end else begin
            if (!kb.kb_we || kb.kb_wrdata !== e.word || kb.kb_wraddr !== 32'h0) begin
              errors++;
              $display("FAIL write_event: got we=%0b data=0x%08h addr=0x%08h expected data=0x%08h addr=0",
                       kb.kb_we, kb.kb_wrdata, kb.kb_wraddr, e.word);
            end
          end
        end
      end
    end
  end

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  // Drive the first nbits bits of a frame for code.
  task automatic send_frame(input logic [7:0] code, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
  endtask

  // Bounded wait for the scoreboard to drain.
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    check(name, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic expect_write(input logic [31:0] w);
    exp_t e;
    e.is_err = 1'b0;
    e.word   = w;
    q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.word   = '0;
    q.push_back(e);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 32'h0001001C};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 32'h0002021C};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{8'h75, 1'b0, 1'b1, 1'b0, 32'h00030375};
    vecs[6]  = '{8'h1C, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[7]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 32'h0004001C};
    vecs[8]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{8'h5A, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[10] = '{8'h5A, 1'b0, 1'b1, 1'b0, 32'h0005005A};
    vecs[11] = '{8'h00, 1'b0, 1'b1, 1'b0, 32'h00060000};

    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rst_n    = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_we",     32'(kb.kb_we),     32'd0);
    check("reset_wrdata", kb.kb_wrdata,      32'd0);
    check("reset_wraddr", kb.kb_wraddr,      32'd0);
    check("reset_ferr",   32'(kb.frame_err), 32'd0);
    @(posedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].exp_we)  expect_write(vecs[i].exp_word);
      if (vecs[i].exp_err) expect_err();
      send_frame(vecs[i].code, vecs[i].bad_par, 11);
      drain($sformatf("vec%0d_drain", i), 40);
    end

    // Timeout after 5 bits, then a full frame.
    expect_err();
    send_frame(8'h33, 1'b0, 5);
    drain("timeout_err", TMO + 60);
    expect_write(32'h00070029);
    send_frame(8'h29, 1'b0, 11);
    drain("after_timeout", 40);

    // Timeout keeps a pending E0 prefix.
    send_frame(8'hE0, 1'b0, 11);
    expect_err();
    send_frame(8'h44, 1'b0, 3);
    drain("timeout_keep_ext", TMO + 60);
    expect_write(32'h00080129);
    send_frame(8'h29, 1'b0, 11);
    drain("ext_after_timeout", 40);

    // Reset mid-frame.
    send_frame(8'h1C, 1'b0, 4);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_we",     32'(kb.kb_we),     32'd0);
    check("midrst_wrdata", kb.kb_wrdata,      32'd0);
    check("midrst_wraddr", kb.kb_wraddr,      32'd0);
    check("midrst_ferr",   32'(kb.frame_err), 32'd0);
    @(posedge clk);
    rst_n = 1'b1;
    repeat (TMO + 20) @(posedge clk);
    check("midrst_quiet", 32'(q.size()), 32'd0);
    expect_write(32'h0001001C);
    send_frame(8'h1C, 1'b0, 11);
    drain("after_reset", 40);

    // Sequence wrap from 0xFFFF.
    force dut.seq = 16'hFFFF;
    expect_write(32'h0000001D);
    send_frame(8'h1D, 1'b0, 11);
    drain("seq_wrap", 40);
    release dut.seq;
    repeat (4) @(posedge clk);
    #1;
    check("hold_wrdata", kb.kb_wrdata, 32'h0000001D);

    repeat (10) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
